stack_control_unit: RTL and testbench
=====================================

Name: stack_control_unit

Overview:
- Multi-cycle fetch/decode sequencer that drives the stack datapath (integration_push_pop) control inputs stackOP, aluOP, mux_selector and immediate from a program stored in instruction memory.
- Replaces bench-driven control sequences (pushi/add/dup/drop/slt) with decoded instructions.
- Sits between a synchronous-read instruction ROM and the datapath. Datapath Overflow and a top-of-stack-zero flag feed back to it.

Parameters:
- ADDR_W, 12, instruction address width (pc and imem_addr).
- RESET_PC, 0, pc value loaded on reset.

Ports:
- CLK  input  1  system clock, rising-edge.
- reset  input  1  asynchronous, active-high reset.
- run  input  1  1 = sequencer advances; 0 = freeze state, outputs NOP.
- imem_addr  output  ADDR_W  instruction memory address.
- imem_data  input  16  instruction memory read data, valid one cycle after imem_addr.
- tos_zero  input  1  datapath top-of-stack == 0.
- Overflow  input  1  datapath arithmetic overflow.
- stackOP  output  3  0 hold, 1 push, 2 binary op (pop2/push), 3 drop.
- aluOP  output  4  ALU function passed to the datapath.
- mux_selector  output  3  0 ALU result, 1 immediate.
- immediate  output  16  immediate value for push.
- pc  output  ADDR_W  current program counter.
- halted  output  1  sequencer in HALT state.
- fault  output  1  sticky; set on overflow halt (and trap, see optional feature).

Behaviour:
- Instruction word: op = imem_data[15:12], arg = imem_data[11:0].
- Opcodes:
  - 0 NOP.
  - 1 PUSHI: next word is the 16-bit immediate.
  - 2 ALU: aluOP = arg[3:0], stackOP = 2, mux = 0.
  - 3 DUP: stackOP = 1, aluOP = 5, mux = 0.
  - 4 DROP: stackOP = 3.
  - 5 JMP: pc = arg[ADDR_W-1:0].
  - 6 BZ: if tos_zero, pc = arg, else pc + 1. No stack effect.
  - 7 HALT.
  - 8-15: illegal.
- FSM states: FETCH, EXEC, IMM_FETCH, IMM_EXEC, HALT.
- FETCH:
  - imem_addr = pc; outputs NOP.
  - If Overflow == 1: go to HALT, set fault. Otherwise go to EXEC.
- EXEC:
  - Decode imem_data and drive control outputs for exactly this one cycle.
  - PUSHI: pc += 1, go to IMM_FETCH, outputs NOP.
  - JMP/BZ: load pc as above.
  - HALT: go to HALT, pc unchanged.
  - Others: pc += 1, go to FETCH.
- IMM_FETCH: imem_addr = pc; outputs NOP; go to IMM_EXEC.
- IMM_EXEC:
  - stackOP = 1, mux_selector = 1, immediate = imem_data.
  - pc += 1, go to FETCH.
- HALT:
  - Outputs NOP, halted = 1.
  - Left only by reset.
- Timing:
  - Normal instruction = 2 cycles; PUSHI = 4 cycles.
  - Control outputs are registered decodes, valid for one full cycle. The datapath acts on them at the next rising CLK edge.
- NOP outputs: stackOP = 0, aluOP = 0, mux_selector = 0. immediate holds its last value.
- pc arithmetic wraps modulo 2^ADDR_W: pc = 2^ADDR_W-1 increments to 0.
- run == 0:
  - State, pc and fault hold.
  - Control outputs forced to NOP, so an EXEC cycle frozen by run is not issued twice.
  - When run returns to 1, the pending state re-executes once.
- Reset (asserted any time, including mid-PUSHI):
  - State FETCH, pc = RESET_PC.
  - stackOP/aluOP/mux_selector/immediate = 0.
  - halted = 0, fault = 0.
- Overflow is sampled only in FETCH, i.e. after the previous instruction's datapath edge.

Optional Feature:
- Macro: STACK_CTRL_TRAP_EN.
- Defined: an illegal opcode in EXEC issues no datapath operation, goes to HALT, and sets fault.
- Undefined: an illegal opcode executes as NOP (pc += 1); fault only reflects overflow.

Test Plan:
- Program {0x1000, 0x0001, 0x1000, 0x0002, 0x2000, 0x7000}, run = 1:
  - stackOP/mux sequence 1/1 (imm 1), 1/1 (imm 2), 2/0 with aluOP 0.
  - halted = 1 at pc = 5.
  - First push issued in cycle 4 after reset release.
- DUP then DROP → stackOP 1/aluOP 5, then stackOP 3, each single-cycle pulses separated by a NOP cycle.
- BZ 0x010:
  - tos_zero = 1 → pc = 0x010.
  - tos_zero = 0 → pc = previous+1.
  - JMP 0xFFF then NOP → pc wraps 0xFFF→0x000.
- Overflow = 1 during FETCH after an ALU instruction → HALT, fault = 1, no further non-zero stackOP until reset.
- run low during EXEC of ALU instruction for 3 cycles → stackOP stays 0; on run high, exactly one stackOP = 2 pulse. Reset asserted during IMM_FETCH → immediately pc = RESET_PC, outputs 0, no push issued.
- Opcode 0x9000:
  - With STACK_CTRL_TRAP_EN: halted = 1, fault = 1.
  - Without it: pc += 1, execution continues.

Source files
------------

// File: rtl/stack_control_unit.sv
// stack_control_unit: fetch/decode sequencer for the stack datapath; 2 cycles per instruction, 4 for PUSHI.
// run=0 freezes state and forces NOP; define STACK_CTRL_TRAP_EN to halt with fault on illegal opcodes.
module stack_control_unit #(
   parameter int ADDR_W   = 12,
   parameter int RESET_PC = 0
) (
   input  logic              CLK,
   input  logic              reset,
   input  logic              run,
   output logic [ADDR_W-1:0] imem_addr,
   input  logic [15:0]       imem_data,
   input  logic              tos_zero,
   input  logic              Overflow,
   output logic [2:0]        stackOP,
   output logic [3:0]        aluOP,
   output logic [2:0]        mux_selector,
   output logic [15:0]       immediate,
   output logic [ADDR_W-1:0] pc,
   output logic              halted,
   output logic              fault
);

   localparam logic [ADDR_W-1:0] PC_INIT = ADDR_W'(RESET_PC);

   localparam logic [3:0] OP_NOP   = 4'd0;
   localparam logic [3:0] OP_PUSHI = 4'd1;
   localparam logic [3:0] OP_ALU   = 4'd2;
   localparam logic [3:0] OP_DUP   = 4'd3;
   localparam logic [3:0] OP_DROP  = 4'd4;
   localparam logic [3:0] OP_JMP   = 4'd5;
   localparam logic [3:0] OP_BZ    = 4'd6;
   localparam logic [3:0] OP_HALT  = 4'd7;

   localparam logic [2:0] SOP_PUSH = 3'd1;
   localparam logic [2:0] SOP_BIN  = 3'd2;
   localparam logic [2:0] SOP_DROP = 3'd3;

   typedef enum logic [2:0] {
      S_FETCH,
      S_EXEC,
      S_IMM_FETCH,
      S_IMM_EXEC,
      S_HALT
   } state_t;

   state_t            state;
   logic [15:0]       imm_q;
   logic [3:0]        op;
   logic [11:0]       arg;
   logic [ADDR_W-1:0] pc_inc;
   logic [ADDR_W-1:0] jmp_tgt;

   assign op        = imem_data[15:12];
   assign arg       = imem_data[11:0];
   assign pc_inc    = pc + ADDR_W'(1);
   assign jmp_tgt   = ADDR_W'(arg);
   assign imem_addr = pc;
   assign halted    = (state == S_HALT);

   always_ff @(posedge CLK or posedge reset) begin
      if (reset) begin
         state <= S_FETCH;
         pc    <= PC_INIT;
         fault <= 1'b0;
         imm_q <= 16'h0000;
      end else if (run) begin
         case (state)
            S_FETCH: begin
               // Overflow here reflects the previous instruction's datapath edge.
               if (Overflow) begin
                  state <= S_HALT;
                  fault <= 1'b1;
               end else begin
                  state <= S_EXEC;
               end
            end
            S_EXEC: begin
               case (op)
                  OP_PUSHI: begin
                     pc    <= pc_inc;
                     state <= S_IMM_FETCH;
                  end
                  OP_JMP: begin
                     pc    <= jmp_tgt;
                     state <= S_FETCH;
                  end
                  OP_BZ: begin
                     pc    <= tos_zero ? jmp_tgt : pc_inc;
                     state <= S_FETCH;
                  end
                  OP_HALT: state <= S_HALT;
                  OP_NOP, OP_ALU, OP_DUP, OP_DROP: begin
                     pc    <= pc_inc;
                     state <= S_FETCH;
                  end
                  default: begin
`ifdef STACK_CTRL_TRAP_EN
                     state <= S_HALT;
                     fault <= 1'b1;
`else
                     pc    <= pc_inc;
                     state <= S_FETCH;
`endif
                  end
               endcase
            end
            S_IMM_FETCH: state <= S_IMM_EXEC;
            S_IMM_EXEC: begin
               imm_q <= imem_data;
               pc    <= pc_inc;
               state <= S_FETCH;
            end
            S_HALT:  state <= S_HALT;
            default: state <= S_FETCH;
         endcase
      end
   end

   // Decodes depend only on the state register and the ROM's output register,
   // so each control value is stable for the whole cycle it is issued in.
   always_comb begin
      stackOP      = 3'd0;
      aluOP        = 4'd0;
      mux_selector = 3'd0;
      immediate    = imm_q;
      if (run) begin
         case (state)
            S_EXEC: begin
               case (op)
                  OP_ALU: begin
                     stackOP = SOP_BIN;
                     aluOP   = arg[3:0];
                  end
                  OP_DUP: begin
                     stackOP = SOP_PUSH;
                     aluOP   = 4'd5;
                  end
                  OP_DROP: stackOP = SOP_DROP;
                  default: ;
               endcase
            end
            S_IMM_EXEC: begin
               stackOP      = SOP_PUSH;
               mux_selector = 3'd1;
               immediate    = imem_data;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_stack_control_unit.sv
// Bench for stack_control_unit: instruction-level model expands each program into per-cycle expectations.
module tb_stack_control_unit;

   logic        CLK = 1'b0;
   logic        reset = 1'b0;
   logic        run = 1'b0;
   logic        tos_zero = 1'b0;
   logic        Overflow = 1'b0;
   logic [11:0] imem_addr;
   logic [15:0] imem_data = 16'h0000;
   logic [2:0]  stackOP;
   logic [3:0]  aluOP;
   logic [2:0]  mux_selector;
   logic [15:0] immediate;
   logic [11:0] pc;
   logic        halted;
   logic        fault;

   logic [15:0] rom [0:4095];

   typedef struct {
      logic [2:0]  st;
      logic [3:0]  al;
      logic [2:0]  mx;
      logic [15:0] im;
      logic [11:0] pc;
      bit          hl;
      bit          ft;
      bit          ov;
   } ent_t;

   ent_t tr[$];
   int   n_chk = 0;
   int   n_err = 0;
   int   n2 = 0;
   int   cyc_i = 0;
   bit   tz_g = 1'b0;

   stack_control_unit #(.ADDR_W(12), .RESET_PC(0)) dut (
      .CLK(CLK), .reset(reset), .run(run), .imem_addr(imem_addr), .imem_data(imem_data),
      .tos_zero(tos_zero), .Overflow(Overflow), .stackOP(stackOP), .aluOP(aluOP),
      .mux_selector(mux_selector), .immediate(immediate), .pc(pc), .halted(halted), .fault(fault)
   );

   always #5 CLK = ~CLK;

   // Synchronous-read instruction ROM.
   always @(posedge CLK) imem_data <= rom[imem_addr];

   task automatic chk(input string nm, input int a, input int e);
      n_chk++;
      if (a != e) begin
         n_err++;
         $display("FAIL %s (cycle %0d): got %0h, expected %0h", nm, cyc_i, a, e);
      end
   endtask

   task automatic add(input logic [2:0] st, input logic [3:0] al, input logic [2:0] mx,
                      input logic [15:0] im, input logic [11:0] p, input bit hl, input bit ft, input bit ov);
      ent_t e;
      e.st = st; e.al = al; e.mx = mx; e.im = im; e.pc = p; e.hl = hl; e.ft = ft; e.ov = ov;
      tr.push_back(e);
   endtask

   task automatic add_nop(input logic [15:0] im, input logic [11:0] p, input bit hl, input bit ft, input bit ov);
      add(3'd0, 4'd0, 3'd0, im, p, hl, ft, ov);
   endtask

   // Interpret the program instruction by instruction: a normal instruction is a
   // NOP fetch cycle plus one issue cycle, PUSHI is fetch/decode/imm-fetch/push.
   task automatic build_trace(input int ncyc, input bit tz, input int ovf_n);
      logic [11:0] p;
      logic [15:0] li;
      logic [15:0] w;
      bit          f;
      bit          stop;
      int          n;
      p = 12'h000; li = 16'h0000; f = 1'b0; stop = 1'b0; n = 0;
      tr.delete();
      while (tr.size() < ncyc && !stop) begin
         if (n == ovf_n) begin
            add_nop(li, p, 1'b0, f, 1'b1);
            f = 1'b1;
            stop = 1'b1;
         end else begin
            add_nop(li, p, 1'b0, f, 1'b0);
            w = rom[p];
            case (w[15:12])
               4'd0: begin add_nop(li, p, 1'b0, f, 1'b0); p = p + 12'd1; end
               4'd1: begin
                  add_nop(li, p, 1'b0, f, 1'b0);
                  p = p + 12'd1;
                  add_nop(li, p, 1'b0, f, 1'b0);
                  li = rom[p];
                  add(3'd1, 4'd0, 3'd1, li, p, 1'b0, f, 1'b0);
                  p = p + 12'd1;
               end
               4'd2: begin add(3'd2, w[3:0], 3'd0, li, p, 1'b0, f, 1'b0); p = p + 12'd1; end
               4'd3: begin add(3'd1, 4'd5, 3'd0, li, p, 1'b0, f, 1'b0); p = p + 12'd1; end
               4'd4: begin add(3'd3, 4'd0, 3'd0, li, p, 1'b0, f, 1'b0); p = p + 12'd1; end
               4'd5: begin add_nop(li, p, 1'b0, f, 1'b0); p = w[11:0]; end
               4'd6: begin add_nop(li, p, 1'b0, f, 1'b0); p = tz ? w[11:0] : p + 12'd1; end
               4'd7: begin add_nop(li, p, 1'b0, f, 1'b0); stop = 1'b1; end
               default: begin
                  add_nop(li, p, 1'b0, f, 1'b0);
`ifdef STACK_CTRL_TRAP_EN
                  f = 1'b1;
                  stop = 1'b1;
`else
                  p = p + 12'd1;
`endif
               end
            endcase
            n++;
         end
      end
      while (tr.size() < ncyc) add_nop(li, p, 1'b1, f, 1'b0);
   endtask

   // One cycle: drive at posedge+1, compare at negedge, return at next posedge+1.
   task automatic cyc(input ent_t e, input bit r, input logic [15:0] held);
      run = r;
      Overflow = r ? e.ov : 1'b0;
      tos_zero = tz_g;
      @(negedge CLK);
      if (r) begin
         chk("stackOP", stackOP, e.st);
         chk("aluOP", aluOP, e.al);
         chk("mux_selector", mux_selector, e.mx);
         chk("immediate", immediate, e.im);
      end else begin
         chk("frozen_stackOP", stackOP, 0);
         chk("frozen_aluOP", aluOP, 0);
         chk("frozen_mux", mux_selector, 0);
         chk("frozen_immediate", immediate, held);
      end
      chk("pc", pc, e.pc);
      chk("halted", halted, e.hl);
      chk("fault", fault, e.ft);
      if (stackOP == 3'd2) n2++;
      @(posedge CLK);
      #1;
   endtask

   task automatic run_trace(input int nmax, input int frz_at, input int frz_len);
      n2 = 0;
      for (int i = 0; i < nmax && i < tr.size(); i++) begin
         cyc_i = i;
         if (i == frz_at) begin
            for (int k = 0; k < frz_len; k++) cyc(tr[i], 1'b0, tr[i-1].im);
         end
         cyc(tr[i], 1'b1, 16'h0000);
      end
      run = 1'b1;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      run = 1'b1;
      Overflow = 1'b0;
      tos_zero = tz_g;
      cyc_i = -1;
      @(negedge CLK);
      chk("rst_stackOP", stackOP, 0);
      chk("rst_aluOP", aluOP, 0);
      chk("rst_mux", mux_selector, 0);
      chk("rst_immediate", immediate, 0);
      chk("rst_pc", pc, 0);
      chk("rst_halted", halted, 0);
      chk("rst_fault", fault, 0);
      @(posedge CLK);
      #1;
      reset = 1'b0;
   endtask

   task automatic rom_clear();
      for (int a = 0; a < 4096; a++) rom[a] = 16'h0000;
   endtask

   initial begin
      rom_clear();
      #1;

      // Two pushes, add, halt.
      rom[0] = 16'h1000; rom[1] = 16'h0001; rom[2] = 16'h1000;
      rom[3] = 16'h0002; rom[4] = 16'h2000; rom[5] = 16'h7000;
      tz_g = 1'b0;
      build_trace(16, 1'b0, -1);
      chk("model_pre_push", tr[2].st, 0);
      chk("model_push1_stackOP", tr[3].st, 1);
      chk("model_push1_mux", tr[3].mx, 1);
      chk("model_push1_imm", tr[3].im, 16'h0001);
      chk("model_push2_imm", tr[7].im, 16'h0002);
      chk("model_add_stackOP", tr[9].st, 2);
      chk("model_halt_pc", tr[12].pc, 5);
      chk("model_halt", tr[12].hl, 1);
      do_reset();
      run_trace(16, -1, 0);
      chk("prog1_halted", halted, 1);
      chk("prog1_pc", pc, 5);
      chk("prog1_fault", fault, 0);

      // DUP then DROP.
      rom_clear();
      rom[0] = 16'h3000; rom[1] = 16'h4000; rom[2] = 16'h7000;
      build_trace(10, 1'b0, -1);
      chk("model_dup_stackOP", tr[1].st, 1);
      chk("model_dup_aluOP", tr[1].al, 5);
      chk("model_gap", tr[2].st, 0);
      chk("model_drop_stackOP", tr[3].st, 3);
      do_reset();
      run_trace(10, -1, 0);

      // BZ taken.
      rom_clear();
      rom[0] = 16'h6010; rom[1] = 16'h7000; rom[16] = 16'h7000;
      tz_g = 1'b1;
      build_trace(8, 1'b1, -1);
      chk("model_bz_taken_pc", tr[2].pc, 12'h010);
      do_reset();
      run_trace(8, -1, 0);
      chk("bz_taken_pc", pc, 12'h010);

      // BZ not taken.
      tz_g = 1'b0;
      build_trace(8, 1'b0, -1);
      chk("model_bz_fall_pc", tr[2].pc, 12'h001);
      do_reset();
      run_trace(8, -1, 0);
      chk("bz_fall_pc", pc, 12'h001);

      // JMP to the top address, NOP there wraps pc to 0.
      rom_clear();
      rom[0] = 16'h5FFF; rom[12'hFFF] = 16'h0000;
      build_trace(12, 1'b0, -1);
      chk("model_jmp_pc", tr[2].pc, 12'hFFF);
      chk("model_wrap_pc", tr[4].pc, 12'h000);
      do_reset();
      run_trace(12, -1, 0);

      // Overflow seen in the fetch after the ALU instruction.
      rom_clear();
      rom[0] = 16'h1000; rom[1] = 16'h0003; rom[2] = 16'h1000; rom[3] = 16'h0004;
      rom[4] = 16'h2000; rom[5] = 16'h0000; rom[6] = 16'h0000; rom[7] = 16'h7000;
      build_trace(20, 1'b0, 3);
      chk("model_ovf_alu", tr[9].st, 2);
      chk("model_ovf_fetch", tr[10].ov, 1);
      chk("model_ovf_fault", tr[11].ft, 1);
      do_reset();
      run_trace(20, -1, 0);
      chk("ovf_halted", halted, 1);
      chk("ovf_fault", fault, 1);
      chk("ovf_pc", pc, 5);

      // run low for 3 cycles during the ALU issue cycle.
      rom_clear();
      rom[0] = 16'h1000; rom[1] = 16'h0005; rom[2] = 16'h2001; rom[3] = 16'h7000;
      build_trace(12, 1'b0, -1);
      chk("model_frz_alu", tr[5].st, 2);
      chk("model_frz_aluop", tr[5].al, 1);
      do_reset();
      run_trace(12, 5, 3);
      chk("frz_alu_pulses", n2, 1);

      // Reset asserted in the immediate fetch of the second PUSHI.
      rom_clear();
      rom[0] = 16'h1000; rom[1] = 16'h1234; rom[2] = 16'h1000; rom[3] = 16'hABCD; rom[4] = 16'h7000;
      build_trace(14, 1'b0, -1);
      chk("model_imm_fetch_pc", tr[6].pc, 3);
      do_reset();
      run_trace(6, -1, 0);
      chk("mid_imm_held", immediate, 16'h1234);
      chk("mid_pc", pc, 3);
      #1 reset = 1'b1;
      #1;
      chk("async_rst_pc", pc, 0);
      chk("async_rst_stackOP", stackOP, 0);
      chk("async_rst_immediate", immediate, 0);
      chk("async_rst_mux", mux_selector, 0);
      do_reset();
      run_trace(14, -1, 0);

      // Illegal opcode.
      rom_clear();
      rom[0] = 16'h9000; rom[1] = 16'h7000;
      build_trace(8, 1'b0, -1);
`ifdef STACK_CTRL_TRAP_EN
      chk("model_trap_fault", tr[2].ft, 1);
      do_reset();
      run_trace(8, -1, 0);
      chk("trap_halted", halted, 1);
      chk("trap_fault", fault, 1);
      chk("trap_pc", pc, 0);
`else
      chk("model_illegal_pc", tr[2].pc, 1);
      do_reset();
      run_trace(8, -1, 0);
      chk("illegal_halted", halted, 1);
      chk("illegal_fault", fault, 0);
      chk("illegal_pc", pc, 1);
`endif

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
